// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMEM port arbiter: arbitration states and owner encoding.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t OWN_CPU = 1'b0;
  localparam owner_t OWN_LDR = 1'b1;

endpackage : dmem_arb_pkg

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of CPU, loader and DMEM-side signals around the arbiter.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_lock;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface : dmem_port_arbiter_if

// File: rtl/dmem_resp_pipe.sv
// One-stage read-response tracker: remembers who issued an accepted read and
// raises that requester's rvalid in the following cycle.
module dmem_resp_pipe
  import dmem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_rd_acc,
  input  owner_t i_owner,
  output logic   o_cpu_rvalid,
  output logic   o_ldr_rvalid
);

  logic   r_valid;
  owner_t r_owner;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_owner <= OWN_CPU;
    end else begin
      r_valid <= i_rd_acc;
      r_owner <= i_owner;
    end
  end

  // Gate with reset so a response in flight is dropped as soon as reset asserts.
  assign o_cpu_rvalid = reset & r_valid & (r_owner == OWN_CPU);
  assign o_ldr_rvalid = reset & r_valid & (r_owner == OWN_LDR);

endmodule : dmem_resp_pipe

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing single-port DMEM between the CPU and a loader,
// with a loader burst lock bounded by a CPU starvation guard.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset,
  dmem_port_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  arb_state_e       r_state;
  owner_t           r_last_gnt;
  logic [CNT_W-1:0] r_lock_cnt;

  arb_state_e       w_state_nxt;
  owner_t           w_last_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cpu_gnt;
  logic             w_ldr_gnt;
  logic             w_mem_en;
  logic             w_mem_we;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ARB;
      r_last_gnt <= OWN_LDR;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_nxt;
      r_lock_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_ldr_gnt   = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_lock_cnt;

    case (r_state)
      ARB: begin
        if (bus.cpu_req && bus.ldr_req) begin
          w_cpu_gnt = (r_last_gnt == OWN_LDR);
          w_ldr_gnt = (r_last_gnt == OWN_CPU);
        end else begin
          w_cpu_gnt = bus.cpu_req;
          w_ldr_gnt = bus.ldr_req;
        end
        // Lock is only taken on an actual loader grant.
        if (w_ldr_gnt && bus.ldr_lock) begin
          w_state_nxt = LOCK;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      LOCK: begin
        w_ldr_gnt = bus.ldr_req;
        if (!bus.ldr_lock) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end else if (r_lock_cnt == CNT_MAX) begin
          if (bus.cpu_req) w_state_nxt = FORCE;
        end else begin
          w_cnt_nxt = r_lock_cnt + CNT_W'(1);
        end
      end
      FORCE: begin
        w_cpu_gnt = bus.cpu_req;
        if (bus.cpu_req) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ARB;
        w_cnt_nxt   = '0;
      end
    endcase

    if (!reset) begin
      w_cpu_gnt = 1'b0;
      w_ldr_gnt = 1'b0;
    end
  end

  always_comb begin
    w_last_nxt = r_last_gnt;
    if (w_cpu_gnt)      w_last_nxt = OWN_CPU;
    else if (w_ldr_gnt) w_last_nxt = OWN_LDR;
  end

  assign w_mem_en = w_cpu_gnt | w_ldr_gnt;
  assign w_mem_we = (w_cpu_gnt & bus.cpu_we) | (w_ldr_gnt & bus.ldr_we);

  assign bus.cpu_gnt   = w_cpu_gnt;
  assign bus.ldr_gnt   = w_ldr_gnt;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_cpu_gnt ? bus.cpu_addr  : (w_ldr_gnt ? bus.ldr_addr  : '0);
  assign bus.mem_wdata = w_cpu_gnt ? bus.cpu_wdata : (w_ldr_gnt ? bus.ldr_wdata : '0);
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.ldr_rdata = bus.mem_rdata;

  dmem_resp_pipe u_resp_pipe (
    .clk          (clk),
    .reset        (reset),
    .i_rd_acc     (w_mem_en & ~w_mem_we),
    .i_owner      (w_ldr_gnt ? OWN_LDR : OWN_CPU),
    .o_cpu_rvalid (bus.cpu_rvalid),
    .o_ldr_rvalid (bus.ldr_rvalid)
  );

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port DMEM.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LOCK_MAX = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem_arr [2**ADDR_W];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    bus.ldr_lock = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] outs;
    idle();
    reset = 1'b0;
    bus.cpu_req = 1'b1;
    bus.ldr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      outs = {bus.cpu_gnt, bus.ldr_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.ldr_rvalid};
      checks++;
      if (outs !== 6'b0) begin
        failures++; $display("FAIL reset_outputs_quiet cycle=%0d got=%b exp=000000", i, outs);
      end
    end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b10) begin
      failures++; $display("FAIL reset_first_winner got=%b exp=10", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL reset_second_winner got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
    checks++;
    if ({bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_rdata} !== {2'b10, 16'h00AA}) begin
      failures++; $display("FAIL reset_first_resp got=%b/%h exp=10/00aa", {bus.cpu_rvalid, bus.ldr_rvalid}, bus.cpu_rdata);
    end
    @(negedge clk); idle(); #1;
    checks++;
    if ({bus.cpu_rvalid, bus.ldr_rvalid} !== 2'b01) begin
      failures++; $display("FAIL reset_second_resp got=%b exp=01", {bus.cpu_rvalid, bus.ldr_rvalid});
    end
  endtask

  task automatic test_contention();
    logic        exp_cpu;
    logic        prev_cpu;
    logic [15:0] prev_data;
    @(negedge clk);
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h10;
    bus.ldr_req = 1'b1; bus.ldr_addr = 8'h20;
    prev_cpu  = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_cpu = (i % 2 == 0);
      checks++;
      if ({bus.cpu_gnt, bus.ldr_gnt} !== {exp_cpu, ~exp_cpu}) begin
        failures++; $display("FAIL contention_grant cycle=%0d got=%b exp=%b", i, {bus.cpu_gnt, bus.ldr_gnt}, {exp_cpu, ~exp_cpu});
      end
      checks++;
      if (bus.mem_addr !== (exp_cpu ? 8'h10 : 8'h20)) begin
        failures++; $display("FAIL contention_addr cycle=%0d got=%h exp=%h", i, bus.mem_addr, exp_cpu ? 8'h10 : 8'h20);
      end
      if (i > 0) begin
        checks++;
        if ({bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_rdata} !== {prev_cpu, ~prev_cpu, prev_data}) begin
          failures++; $display("FAIL contention_resp cycle=%0d got=%b/%h exp=%b/%h", i,
                               {bus.cpu_rvalid, bus.ldr_rvalid}, bus.cpu_rdata, {prev_cpu, ~prev_cpu}, prev_data);
        end
      end
      prev_cpu  = exp_cpu;
      prev_data = exp_cpu ? 16'h1111 : 16'h2222;
    end
    @(negedge clk); idle(); #1;
    checks++;
    if ({bus.cpu_rvalid, bus.ldr_rvalid, bus.ldr_rdata} !== {2'b01, 16'h2222}) begin
      failures++; $display("FAIL contention_last_resp got=%b/%h exp=01/2222", {bus.cpu_rvalid, bus.ldr_rvalid}, bus.ldr_rdata);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    idle();
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 8'h05; bus.ldr_wdata = 16'hBEEF;
    #1;
    checks++;
    if ({bus.ldr_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b111, 8'h05, 16'hBEEF}) begin
      failures++; $display("FAIL write_accept got=%b%b%b/%h/%h exp=111/05/beef",
                           bus.ldr_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h05;
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_rvalid, bus.mem_we} !== 3'b100) begin
      failures++; $display("FAIL write_no_resp got=%b exp=100", {bus.cpu_gnt, bus.ldr_rvalid, bus.mem_we});
    end
    @(negedge clk); idle(); #1;
    checks++;
    if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 16'hBEEF}) begin
      failures++; $display("FAIL write_readback got=%b/%h exp=1/beef", bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_lock();
    @(negedge clk);
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h05;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_addr = 8'h30; bus.ldr_wdata = 16'h1234;
    bus.ldr_lock = 1'b1;
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL lock_entry got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
    for (int k = 1; k <= LOCK_MAX; k++) begin
      @(negedge clk); #1;
      checks++;
      if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
        failures++; $display("FAIL lock_hold cycle=%0d got=%b exp=01", k, {bus.cpu_gnt, bus.ldr_gnt});
      end
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b10) begin
      failures++; $display("FAIL lock_force_slot got=%b exp=10", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL lock_reenter got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL lock_resumed got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
  endtask

  task automatic test_lock_release();
    @(negedge clk);
    bus.ldr_lock = 1'b0;
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL release_same_cycle got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b10) begin
      failures++; $display("FAIL release_rr_cpu got=%b exp=10", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL release_rr_ldr got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); idle();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 8'h05;
    #1;
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      failures++; $display("FAIL midrd_accept got=%b exp=1", bus.cpu_gnt);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.ldr_req = 1'b1; bus.ldr_lock = 1'b1;
    #1;
    checks++;
    if ({bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_gnt, bus.ldr_gnt, bus.mem_en} !== 5'b0) begin
      failures++; $display("FAIL midrd_dropped got=%b exp=00000",
                           {bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_gnt, bus.ldr_gnt, bus.mem_en});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid} !== 3'b100) begin
      failures++; $display("FAIL midrd_arb_restart got=%b exp=100", {bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid} !== 3'b011) begin
      failures++; $display("FAIL midrd_after_restart got=%b exp=011", {bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid});
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.cpu_gnt, bus.ldr_gnt} !== 2'b01) begin
      failures++; $display("FAIL midrd_lock_taken got=%b exp=01", {bus.cpu_gnt, bus.ldr_gnt});
    end
    @(negedge clk); idle();
  endtask

  initial begin
    for (int a = 0; a < 2**ADDR_W; a++) mem_arr[a] = '0;
    mem_arr[8'h00] = 16'h00AA;
    mem_arr[8'h10] = 16'h1111;
    mem_arr[8'h20] = 16'h2222;
    idle();
    test_reset();
    test_contention();
    test_write();
    test_lock();
    test_lock_release();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_port_arbiter
